// File: rtl/ccu_snoop_arbiter.sv
// ccu_snoop_arbiter
//    Shares the single CCU snoop master port (AC/CR/CD) between NoReq snoop
//    requesters. One transaction is granted at a time using round-robin order.
//    The granted AC request is forwarded to the master port. CR and CD are
//    steered back to the grantee only.
//
// Ports
//    clk_i, rst_i          clock, synchronous active-high reset
//    req_ac_*              per-requester AC channel (payload slice k = requester k)
//    req_cr_*              per-requester CR channel (valid per requester, resp broadcast)
//    req_cd_*              per-requester CD channel (valid per requester, data/last broadcast)
//    snp_ac_*              master AC channel toward the caching masters
//    snp_cr_*, snp_cd_*    master CR / CD channels from the caching masters
//    busy_o                a transaction is granted
//    grant_idx_o           current or last grantee
//    proto_err_o           single-cycle pulse on a snoop protocol violation
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no grant; round-robin pick among requesters with AC valid
// AC      | grantee AC forwarded to the master port until it handshakes
// RESP    | CR/CD passed through to the grantee until the snoop completes
module ccu_snoop_arbiter #(
   parameter int NoReq     = 2,
   parameter int AddrWidth = 32,
   parameter int DataWidth = 64,
   localparam int IdxWidth = (NoReq > 1) ? $clog2(NoReq) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NoReq-1:0]           req_ac_valid_i,
   output logic [NoReq-1:0]           req_ac_ready_o,
   input  logic [NoReq*AddrWidth-1:0] req_ac_addr_i,
   input  logic [NoReq*4-1:0]         req_ac_snoop_i,
   input  logic [NoReq*3-1:0]         req_ac_prot_i,
   output logic [NoReq-1:0]           req_cr_valid_o,
   input  logic [NoReq-1:0]           req_cr_ready_i,
   output logic [4:0]                 req_cr_resp_o,
   output logic [NoReq-1:0]           req_cd_valid_o,
   input  logic [NoReq-1:0]           req_cd_ready_i,
   output logic [DataWidth-1:0]       req_cd_data_o,
   output logic                       req_cd_last_o,
   output logic                       snp_ac_valid_o,
   input  logic                       snp_ac_ready_i,
   output logic [AddrWidth-1:0]       snp_ac_addr_o,
   output logic [3:0]                 snp_ac_snoop_o,
   output logic [2:0]                 snp_ac_prot_o,
   input  logic                       snp_cr_valid_i,
   output logic                       snp_cr_ready_o,
   input  logic [4:0]                 snp_cr_resp_i,
   input  logic                       snp_cd_valid_i,
   output logic                       snp_cd_ready_o,
   input  logic [DataWidth-1:0]       snp_cd_data_i,
   input  logic                       snp_cd_last_i,
   output logic                       busy_o,
   output logic [IdxWidth-1:0]        grant_idx_o,
   output logic                       proto_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AC   = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [IdxWidth-1:0] grant_idx_q, grant_d;
   logic [IdxWidth-1:0] rr_ptr_q, rr_d;
   logic                cr_done_q, cr_done_d;
   logic                cd_done_q, cd_done_d;
   logic                dt_q, dt_d;
   logic                cd_seen_q, cd_seen_d;

   logic [IdxWidth-1:0] arb_idx;
   logic                arb_found;

   logic ac_hs, ac_drop;
   logic cr_rdy, cr_hs;
   logic cd_rdy, cd_hs, cd_drop;
   logic cr_done_nx, cd_done_nx, dt_nx;
   logic xact_done;

   // The AC payload is not registered: requesters hold it stable while valid.
   assign snp_ac_addr_o  = req_ac_addr_i[int'(grant_idx_q)*AddrWidth +: AddrWidth];
   assign snp_ac_snoop_o = req_ac_snoop_i[int'(grant_idx_q)*4 +: 4];
   assign snp_ac_prot_o  = req_ac_prot_i[int'(grant_idx_q)*3 +: 3];

   assign req_cr_resp_o = snp_cr_resp_i;
   assign req_cd_data_o = snp_cd_data_i;
   assign req_cd_last_o = snp_cd_last_i;

   assign busy_o      = (state_q != ST_IDLE);
   assign grant_idx_o = grant_idx_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         grant_idx_q <= '0;
         rr_ptr_q    <= '0;
         cr_done_q   <= 1'b0;
         cd_done_q   <= 1'b0;
         dt_q        <= 1'b0;
         cd_seen_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_d;
         rr_ptr_q    <= rr_d;
         cr_done_q   <= cr_done_d;
         cd_done_q   <= cd_done_d;
         dt_q        <= dt_d;
         cd_seen_q   <= cd_seen_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_idx_q;
      rr_d      = rr_ptr_q;
      cr_done_d = cr_done_q;
      cd_done_d = cd_done_q;
      dt_d      = dt_q;
      cd_seen_d = cd_seen_q;
      arb_found = 1'b0;
      arb_idx   = rr_ptr_q;

      // First requesting index at or above rr_ptr, wrapping around.
      for (int i = 0; i < NoReq; i++) begin
         if (!arb_found && req_ac_valid_i[(int'(rr_ptr_q) + i) % NoReq]) begin
            arb_found = 1'b1;
            arb_idx   = IdxWidth'((int'(rr_ptr_q) + i) % NoReq);
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               state_d = ST_AC;
               grant_d = arb_idx;
               rr_d    = IdxWidth'((int'(arb_idx) + 1) % NoReq);
            end
         end
         ST_AC: begin
            if (ac_drop) begin
               state_d = ST_IDLE;
            end else if (ac_hs) begin
               state_d   = ST_RESP;
               cr_done_d = 1'b0;
               cd_done_d = 1'b0;
               dt_d      = 1'b0;
               cd_seen_d = 1'b0;
            end
         end
         ST_RESP: begin
            cr_done_d = cr_done_nx;
            cd_done_d = cd_done_nx;
            dt_d      = dt_nx;
            cd_seen_d = cd_seen_q | cd_hs;
            if (xact_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ac_ready_o = '0;
      snp_ac_valid_o = 1'b0;
      req_cr_valid_o = '0;
      snp_cr_ready_o = 1'b0;
      req_cd_valid_o = '0;
      snp_cd_ready_o = 1'b0;
      proto_err_o    = 1'b0;
      ac_hs          = 1'b0;
      ac_drop        = 1'b0;
      cr_rdy         = 1'b0;
      cr_hs          = 1'b0;
      cd_rdy         = 1'b0;
      cd_hs          = 1'b0;
      cd_drop        = 1'b0;
      cr_done_nx     = cr_done_q;
      cd_done_nx     = cd_done_q;
      dt_nx          = dt_q;
      xact_done      = 1'b0;

      unique case (state_q)
         ST_AC: begin
            snp_ac_valid_o              = req_ac_valid_i[grant_idx_q];
            req_ac_ready_o[grant_idx_q] = snp_ac_ready_i;
            ac_hs                       = req_ac_valid_i[grant_idx_q] & snp_ac_ready_i;
            ac_drop                     = ~req_ac_valid_i[grant_idx_q];
            proto_err_o                 = ac_drop;
         end
         ST_RESP: begin
            cr_rdy                      = req_cr_ready_i[grant_idx_q] & ~cr_done_q;
            cr_hs                       = snp_cr_valid_i & cr_rdy;
            snp_cr_ready_o              = cr_rdy;
            req_cr_valid_o[grant_idx_q] = snp_cr_valid_i & ~cr_done_q;

            // A CR with DataTransfer=0 means no CD belongs to this snoop; any
            // beat alongside or after it is swallowed rather than forwarded.
            cd_drop = snp_cd_valid_i & ~cd_done_q &
                      (cr_done_q ? ~dt_q : (cr_hs & ~snp_cr_resp_i[0]));
            cd_rdy  = cd_drop | (req_cd_ready_i[grant_idx_q] & ~cd_done_q);
            cd_hs   = snp_cd_valid_i & cd_rdy;
            snp_cd_ready_o              = cd_rdy;
            req_cd_valid_o[grant_idx_q] = snp_cd_valid_i & ~cd_done_q & ~cd_drop;

            cr_done_nx = cr_done_q | cr_hs;
            dt_nx      = cr_hs ? snp_cr_resp_i[0] : dt_q;
            cd_done_nx = cd_done_q | (cd_hs & snp_cd_last_i);
            xact_done  = cr_done_nx & (cd_done_nx | ~dt_nx);

            proto_err_o = cd_drop | (cr_hs & ~snp_cr_resp_i[0] & cd_seen_q);
         end
         default: ;
      endcase
   end

endmodule
